// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master engine among NREQ requesters.
// Optional NACK retry enabled by defining I2C_ARB_RETRY_EN.
module i2c_req_arbiter #(
    parameter int NREQ      = 4,
    parameter int TIMEOUT   = 65535,
    parameter int MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [NREQ-1:0]     req_rw_i,
    input  logic [7*NREQ-1:0]   req_dev_i,
    input  logic [8*NREQ-1:0]   req_reg_i,
    input  logic [8*NREQ-1:0]   req_wdata_i,
    output logic [NREQ-1:0]     req_ack_o,
    output logic [NREQ-1:0]     resp_valid_o,
    output logic [7:0]          resp_rdata_o,
    output logic                resp_nack_o,
    output logic                resp_tmo_o,
    output logic                m_start_o,
    output logic                m_rw_o,
    output logic [6:0]          m_dev_o,
    output logic [7:0]          m_reg_o,
    output logic [7:0]          m_wdata_o,
    input  logic                m_busy_i,
    input  logic                m_done_i,
    input  logic                m_nack_i,
    input  logic [7:0]          m_rdata_i,
    output logic                arb_busy_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("NREQ must be in 2..8");
    end
    if (TIMEOUT < 0 || MAX_RETRY < 0) begin : g_bad_limits
        $error("TIMEOUT and MAX_RETRY must be non-negative");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q;
    logic [IW-1:0]      rr_q;
    logic [IW-1:0]      win_q;
    logic [NREQ-1:0]    req_ack_q;
    logic [NREQ-1:0]    resp_valid_q;
    logic [7:0]         resp_rdata_q;
    logic               resp_nack_q;
    logic               resp_tmo_q;
    logic               m_start_q;
    logic               m_rw_q;
    logic [6:0]         m_dev_q;
    logic [7:0]         m_reg_q;
    logic [7:0]         m_wdata_q;
    logic [TW-1:0]      timer_q;
    logic               grant_d;
    logic [IW-1:0]      win_d;
    logic               do_retry;

`ifdef I2C_ARB_RETRY_EN
    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RCW-1:0]     retry_q;
    assign do_retry = m_nack_i && (int'(retry_q) < MAX_RETRY);
`else
    assign do_retry = 1'b0;
`endif

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Iterate from the far end so the candidate closest to rr_q wins.
    always_comb begin
        grant_d = 1'b0;
        win_d   = rr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[rr_idx(rr_q, k)]) begin
                grant_d = 1'b1;
                win_d   = rr_idx(rr_q, k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            win_q        <= '0;
            req_ack_q    <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_nack_q  <= 1'b0;
            resp_tmo_q   <= 1'b0;
            m_start_q    <= 1'b0;
            m_rw_q       <= 1'b0;
            m_dev_q      <= '0;
            m_reg_q      <= '0;
            m_wdata_q    <= '0;
            timer_q      <= '0;
`ifdef I2C_ARB_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            req_ack_q    <= '0;
            resp_valid_q <= '0;
            m_start_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
`ifdef I2C_ARB_RETRY_EN
                    retry_q <= '0;
`endif
                    if (grant_d) begin
                        win_q            <= win_d;
                        m_rw_q           <= req_rw_i[win_d];
                        m_dev_q          <= req_dev_i[7*int'(win_d) +: 7];
                        m_reg_q          <= req_reg_i[8*int'(win_d) +: 8];
                        m_wdata_q        <= req_wdata_i[8*int'(win_d) +: 8];
                        req_ack_q[win_d] <= 1'b1;
                        state_q          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!m_busy_i) begin
                        m_start_q <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if (m_done_i && do_retry) begin
`ifdef I2C_ARB_RETRY_EN
                        retry_q <= retry_q + 1'b1;
`endif
                        state_q <= S_ISSUE;
                    end else if (m_done_i) begin
                        resp_nack_q  <= m_nack_i;
                        resp_tmo_q   <= 1'b0;
                        resp_rdata_q <= m_rw_q ? m_rdata_i : 8'h00;
                        state_q      <= S_RESP;
                    end else if (TIMEOUT != 0 && timer_q == TMO_LAST) begin
                        resp_nack_q  <= 1'b0;
                        resp_tmo_q   <= 1'b1;
                        resp_rdata_q <= 8'h00;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    resp_valid_q[win_q] <= 1'b1;
                    rr_q    <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ack_o    = req_ack_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_nack_o  = resp_nack_q;
    assign resp_tmo_o   = resp_tmo_q;
    assign m_start_o    = m_start_q;
    assign m_rw_o       = m_rw_q;
    assign m_dev_o      = m_dev_q;
    assign m_reg_o      = m_reg_q;
    assign m_wdata_o    = m_wdata_q;
    assign arb_busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized bench for i2c_req_arbiter with an engine model and a round-robin reference model.
module tb_i2c_req_arbiter;
    localparam int NREQ      = 4;
    localparam int TIMEOUT   = 100;
    localparam int MAX_RETRY = 2;
`ifdef I2C_ARB_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_rw, req_ack, resp_valid;
    logic [7*NREQ-1:0] req_dev;
    logic [8*NREQ-1:0] req_reg, req_wdata;
    logic [7:0]        resp_rdata, m_reg, m_wdata, m_rdata;
    logic              resp_nack, resp_tmo, m_start, m_rw, m_busy, m_done, m_nack, arb_busy;
    logic [6:0]        m_dev;
    logic              eng_busy, tb_busy;

    always #10 clk = ~clk;
    assign m_busy = eng_busy | tb_busy;

    i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_rw_i(req_rw), .req_dev_i(req_dev),
        .req_reg_i(req_reg), .req_wdata_i(req_wdata),
        .req_ack_o(req_ack), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .resp_nack_o(resp_nack), .resp_tmo_o(resp_tmo),
        .m_start_o(m_start), .m_rw_o(m_rw), .m_dev_o(m_dev), .m_reg_o(m_reg),
        .m_wdata_o(m_wdata), .m_busy_i(m_busy), .m_done_i(m_done), .m_nack_i(m_nack),
        .m_rdata_i(m_rdata), .arb_busy_o(arb_busy)
    );

    int checks = 0;
    int errors = 0;
    int ptr;
    int waits [NREQ];
    bit prev_tmo;
    int eng_dly;
    bit eng_nack, eng_hang;
    logic [7:0] eng_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Engine model: busy from m_start until a done pulse eng_dly cycles later; hangs if eng_hang.
    bit e_active = 1'b0;
    int e_cnt = 0;
    initial begin
        eng_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
    end
    always begin
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (rst) begin
            eng_busy = 1'b0;
            e_active = 1'b0;
        end else if (m_start) begin
            eng_busy = !eng_hang;
            e_active = 1'b1;
            e_cnt    = eng_dly;
        end else if (e_active && !eng_hang) begin
            if (e_cnt <= 1) begin
                m_done = 1'b1; m_nack = eng_nack; m_rdata = eng_rd;
                eng_busy = 1'b0; e_active = 1'b0;
            end else begin
                e_cnt--;
            end
        end else if (!e_active) begin
            eng_busy = 1'b0;
        end
    end

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int i, input bit rw, input logic [6:0] d, input logic [7:0] r,
                           input logic [7:0] w);
        req_rw[i] = rw;
        req_dev[7*i +: 7] = d;
        req_reg[8*i +: 8] = r;
        req_wdata[8*i +: 8] = w;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // One full transaction: ack, engine command(s), response; all expectations from the model.
    task automatic run_txn(input int hold_cyc, input bit drop, input bit scramble, output int w);
        logic [NREQ-1:0] onehot;
        int exp_w, lat, cyc, n_start, n_ack, n_vio, t_start, t_tmo, exp_starts;
        bit seen, busy_prev;
        logic e_rw;
        logic [6:0] e_dev;
        logic [7:0] e_reg, e_wd;
        w = -1;
        exp_w = pick(req_valid, ptr);
        if (exp_w < 0) return;
        tb_busy = (hold_cyc > 0);
        lat = 0;
        do begin @(negedge clk); lat++; end while (req_ack == '0 && lat < 20);
        chk("ack_lat", 64'(lat), 64'd1);
        if (req_ack == '0) return;
        onehot = '0;
        onehot[exp_w] = 1'b1;
        chk("ack_grant", 64'(req_ack), 64'(onehot));
        for (int i = 0; i < NREQ; i++)
            if (i != exp_w && req_valid[i]) waits[i]++;
        chk("fair_wait", 64'(waits[exp_w] <= NREQ - 1), 64'd1);
        waits[exp_w] = 0;
        w = exp_w;
        e_rw = req_rw[exp_w]; e_dev = req_dev[7*exp_w +: 7];
        e_reg = req_reg[8*exp_w +: 8]; e_wd = req_wdata[8*exp_w +: 8];
        if (drop) req_valid[exp_w] = 1'b0;
        if (scramble) rand_req(exp_w);
        n_start = 0; n_ack = 0; n_vio = 0; t_start = 0; t_tmo = -1; seen = 1'b0; cyc = 0;
        busy_prev = eng_busy | tb_busy;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (m_start) begin
                n_start++;
                if (busy_prev) n_vio++;
                if (n_start == 1) t_start = cyc;
                chk("m_fields", 64'({m_rw, m_dev, m_reg, m_wdata}), 64'({e_rw, e_dev, e_reg, e_wd}));
            end
            if (req_ack != '0) n_ack++;
            if (resp_tmo && t_tmo < 0) t_tmo = cyc;
            if (resp_valid != '0) seen = 1'b1;
            tb_busy = (cyc < hold_cyc);
            busy_prev = eng_busy | tb_busy;
        end
        tb_busy = 1'b0;
        chk("resp_seen", 64'(seen), 64'd1);
        if (!seen) return;
        exp_starts = (!eng_hang && eng_nack && RETRY_ON) ? MAX_RETRY + 1 : 1;
        chk("resp_grant", 64'(resp_valid), 64'(onehot));
        chk("ack_while_busy", 64'(n_ack), 64'd0);
        chk("start_while_busy", 64'(n_vio), 64'd0);
        chk("start_cnt", 64'(n_start), 64'(exp_starts));
        chk("resp_tmo", 64'(resp_tmo), 64'(eng_hang));
        chk("resp_nack", 64'(resp_nack), 64'(!eng_hang && eng_nack));
        chk("resp_rdata", 64'(resp_rdata), 64'((eng_hang || !e_rw) ? 8'h00 : eng_rd));
        if (eng_hang && !prev_tmo) chk("tmo_lat", 64'(t_tmo - t_start), 64'(TIMEOUT));
        prev_tmo = eng_hang;
        ptr = (exp_w + 1) % NREQ;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat;
        bit seen;
        rst = 1'b1; tb_busy = 1'b0;
        req_valid = '0; req_rw = '0; req_dev = '0; req_reg = '0; req_wdata = '0;
        eng_dly = 4; eng_nack = 1'b0; eng_hang = 1'b0; eng_rd = 8'h00;
        ptr = 0; prev_tmo = 1'b0;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_a", 64'({req_ack, resp_valid, resp_rdata, resp_nack, resp_tmo, m_start, arb_busy}), 64'd0);
        chk("rst_out_b", 64'({m_rw, m_dev, m_reg, m_wdata}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(arb_busy), 64'd0);

        // All requesters held valid: grants must rotate 0,1,2,3,0,1,2,3.
        for (int i = 0; i < NREQ; i++) begin rand_req(i); req_valid[i] = 1'b1; end
        for (int n = 0; n < 8; n++) begin
            eng_dly = $urandom_range(1, 5); eng_rd = 8'($urandom);
            run_txn(0, 1'b0, 1'b0, w);
            chk("rr_order", 64'(w), 64'(n % NREQ));
        end
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;

        // Single write, then a read, then NACK, then timeout followed by another grant.
        set_req(0, 1'b0, 7'h50, 8'h10, 8'hA5); req_valid[0] = 1'b1;
        eng_dly = 20; eng_nack = 1'b0; eng_rd = 8'h77;
        run_txn(0, 1'b1, 1'b1, w);
        set_req(1, 1'b1, 7'h22, 8'h05, 8'h00); req_valid[1] = 1'b1;
        eng_dly = 6; eng_rd = 8'h3C;
        run_txn(0, 1'b1, 1'b0, w);
        set_req(2, 1'b0, 7'h31, 8'h44, 8'h99); req_valid[2] = 1'b1;
        eng_nack = 1'b1;
        run_txn(0, 1'b1, 1'b0, w);
        eng_nack = 1'b0;
        set_req(3, 1'b1, 7'h68, 8'h01, 8'h00); req_valid[3] = 1'b1;
        eng_hang = 1'b1;
        run_txn(0, 1'b1, 1'b0, w);
        eng_hang = 1'b0; eng_dly = 3;
        rand_req(0); req_valid[0] = 1'b1;
        run_txn(2, 1'b1, 1'b0, w);
        chk("after_tmo_grant", 64'(w), 64'd0);

        // Reset while waiting on the engine: no response, pointer back to 0.
        eng_hang = 1'b1;
        rand_req(2); req_valid[2] = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!m_start && lat < 20);
        chk("abort_start", 64'(m_start), 64'd1);
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("abort_busy", 64'(arb_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_a", 64'({req_ack, resp_valid, resp_rdata, resp_nack, resp_tmo, m_start, arb_busy}), 64'd0);
        chk("rst_async_b", 64'({m_rw, m_dev, m_reg, m_wdata}), 64'd0);
        seen = 1'b0;
        repeat (2) begin @(negedge clk); if (resp_valid != '0) seen = 1'b1; end
        rst = 1'b0;
        repeat (2) begin @(negedge clk); if (resp_valid != '0) seen = 1'b1; end
        chk("abort_no_resp", 64'(seen), 64'd0);
        chk("abort_idle", 64'(arb_busy), 64'd0);
        eng_hang = 1'b0; ptr = 0; prev_tmo = 1'b0;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        rand_req(0); rand_req(1); req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        run_txn(0, 1'b1, 1'b0, w);
        chk("post_rst_grant", 64'(w), 64'd0);

        // Randomized traffic: arrivals, drops before ack, busy engine, NACKs, timeouts.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && $urandom_range(0, 9) == 0) begin
                    req_valid[i] = 1'b0; waits[i] = 0;
                end else if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    rand_req(i); req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin rand_req(n % NREQ); req_valid[n % NREQ] = 1'b1; end
            eng_dly = $urandom_range(1, 8); eng_rd = 8'($urandom);
            eng_nack = ($urandom_range(0, 3) == 0);
            eng_hang = ($urandom_range(0, 9) == 0);
            run_txn(($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4), 1'b1,
                    1'($urandom_range(0, 1)), w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
